score_keeper: RTL and testbench
===============================

Name: score_keeper

Overview:
- Producer side of the score path into the 7-segment display controller: derives the score from game geometry and supplies BCD digits for the display to multiplex.
- Watches bird and pillar x-positions on each game tick and counts pillars the bird clears.
- Tracks current and highest score in 4-digit BCD.
- Sits between the game logic (position source) and the segment display driver (digit consumer) in the top level.

Parameters:
- PILLAR_W, 10'd40, pillar width in pixels; a pillar is cleared when its x + PILLAR_W drops below bird_x.
- SCORE_MAX, 16'h9999, BCD saturation value.

Ports:
- clk  in  1  master clock, 100 MHz
- rst_n  in  1  asynchronous active-low reset
- game_tick  in  1  one-clk strobe at game update rate (50 Hz); all scoring is sampled only when high
- game_state  in  1  1 = playing, 0 = idle/over
- bird_x  in  10  bird left-edge x position, pixels
- pillar1_x  in  10  pillar 1 left-edge x
- pillar2_x  in  10  pillar 2 left-edge x
- score_bcd  out  16  current score, 4 BCD digits, [15:12] = thousands
- high_bcd  out  16  highest score, BCD
- disp_bcd  out  16  digits for the segment display
- score_pulse  out  1  one-clk pulse on each score increment
- new_high  out  1  one-clk pulse when high_bcd is updated

Behaviour:
- Reset (rst_n = 0, asynchronous):
  - score_bcd = 0, high_bcd = 0, disp_bcd = 0, pulses = 0.
  - State = IDLE; passed flags = 0.
  - Takes effect immediately mid-game; high score is lost.
- Edge detection: game_state registered once (gs_q); rise = game_state & ~gs_q, fall = ~game_state & gs_q. Edges are evaluated every clk, independent of game_tick.
- States: IDLE, PLAYING, COMMIT, OVER.
  - IDLE -> PLAYING on rise; score_bcd cleared to 0 and both passed flags cleared in the same edge.
  - PLAYING -> COMMIT on fall.
  - COMMIT (exactly 1 clk): if score_bcd > high_bcd, high_bcd <= score_bcd and new_high = 1 for that clk. Then -> OVER.
  - OVER -> PLAYING on rise; score_bcd cleared and flags cleared.
- BCD compare: 16-bit unsigned compare is valid because contents are always legal BCD.
- Scoring (PLAYING and game_tick = 1 only):
  - Per pillar i: end_i = {1'b0, pillarN_x} + PILLAR_W computed at 11 bits, with no wrap.
  - pass_i = (end_i < bird_x) & ~passed_i.
  - Set passed_i when pass_i is true.
  - Clear passed_i when end_i >= bird_x, i.e. the pillar has wrapped back to the right.
  - inc = pass_1 + pass_2 (0..2). Both pillars passing on the same tick adds 2.
  - score_bcd <= sat(score_bcd + inc) on the same clk edge as the tick: 1-clk latency from game_tick.
  - score_pulse = 1 in the following clk when inc != 0.
- Saturation: any result exceeding 9999 holds at 16'h9999; score_pulse still fires.
- Digit carry: BCD carry ripples per digit; a digit never holds a value above 9.
- game_tick coinciding with fall: the fall wins; no score is added on that tick.
- rise while in COMMIT: ignored. Legal only from IDLE/OVER, so that rise is lost; game logic holds game_state >= 2 clks.
- disp_bcd (registered):
  - score_bcd in PLAYING and COMMIT.
  - high_bcd in IDLE and OVER.

Decomposition:
- Shared package/header:
  - state encodings (IDLE = 2'd0, PLAYING = 2'd1, COMMIT = 2'd2, OVER = 2'd3)
  - PILLAR_W default
  - SCORE_MAX
- Sub-module bcd_add_sat: combinational 4-digit BCD + {0,1,2} with saturation to 9999; reused by any future score/timer logic.

Test Plan:
- Reset, then game_state = 1; bird_x = 100, pillar1_x moves from 70 to 59 on a tick (end 110 -> 99) -> score_bcd = 16'h0001 one clk after the tick, score_pulse for 1 clk. Further ticks with pillar1_x < 59 give no additional increment.
- Both pillars cross bird_x = 100 on the same tick with score_bcd = 16'h0009 -> score_bcd = 16'h0011.
- Pillar1 wraps to x = 600, then crosses again -> second increment. Run 12 passes total from 0 -> score_bcd = 16'h0012 (BCD carry checked).
- Force score to 16'h9998, double pass -> 16'h9999 (saturated), score_pulse = 1.
- Score 16'h0012, game_state falls -> next clk COMMIT: high_bcd = 16'h0012, new_high = 1, disp_bcd = 16'h0012. Replay reaching 16'h0005 and fall -> high_bcd unchanged, new_high stays 0.
- Assert rst_n low mid-PLAYING with score 16'h0007 and high 16'h0012 -> all outputs 0 asynchronously, state IDLE. game_tick with no game_state rise -> no scoring.

Source files
------------

// File: rtl/score_keeper_pkg.sv
// Shared widths, defaults and state encoding for the score path.
package score_keeper_pkg;

   localparam int unsigned POS_W  = 10;
   localparam int unsigned END_W  = POS_W + 1;
   localparam int unsigned BCD_W  = 16;
   localparam int unsigned INC_W  = 2;
   localparam int unsigned DIGITS = 4;

   localparam logic [POS_W-1:0] PILLAR_W_DEF  = 10'd40;
   localparam logic [BCD_W-1:0] SCORE_MAX_DEF = 16'h9999;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PLAYING = 2'd1,
      ST_COMMIT  = 2'd2,
      ST_OVER    = 2'd3
   } state_e;

endpackage : score_keeper_pkg

// File: rtl/score_keeper_bcd_add_sat.sv
// Combinational 4-digit BCD plus {0,1,2} with saturation on overflow.
module bcd_add_sat
   import score_keeper_pkg::*;
#(
   parameter logic [BCD_W-1:0] SAT_VALUE = SCORE_MAX_DEF
) (
   input  logic [BCD_W-1:0] bcd_i,
   input  logic [INC_W-1:0] inc_i,
   output logic [BCD_W-1:0] sum_o
);

   logic [BCD_W-1:0] sum;
   logic [INC_W-1:0] carry;
   logic [4:0]       digit;

   // Ripple the increment through the digits; carry out of the top digit saturates.
   always_comb begin
      sum   = '0;
      carry = inc_i;
      digit = '0;
      for (int d = 0; d < int'(DIGITS); d++) begin
         digit = {1'b0, bcd_i[4*d +: 4]} + {3'b000, carry};
         if (digit > 5'd9) begin
            sum[4*d +: 4] = 4'(digit - 5'd10);
            carry         = 2'd1;
         end else begin
            sum[4*d +: 4] = digit[3:0];
            carry         = 2'd0;
         end
      end
      sum_o = (carry != 2'd0) ? SAT_VALUE : sum;
   end

endmodule : bcd_add_sat

// File: rtl/score_keeper.sv
// Counts pillars cleared by the bird, keeps current/high BCD score and display digits.
module score_keeper
   import score_keeper_pkg::*;
#(
   parameter logic [POS_W-1:0] PILLAR_W  = PILLAR_W_DEF,
   parameter logic [BCD_W-1:0] SCORE_MAX = SCORE_MAX_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             game_tick,
   input  logic             game_state,
   input  logic [POS_W-1:0] bird_x,
   input  logic [POS_W-1:0] pillar1_x,
   input  logic [POS_W-1:0] pillar2_x,
   output logic [BCD_W-1:0] score_bcd,
   output logic [BCD_W-1:0] high_bcd,
   output logic [BCD_W-1:0] disp_bcd,
   output logic             score_pulse,
   output logic             new_high
);

   state_e           state_q, state_d;
   logic             gs_q;
   logic [BCD_W-1:0] score_q, score_d;
   logic [BCD_W-1:0] high_q, high_d;
   logic [BCD_W-1:0] disp_q, disp_d;
   logic             pulse_q, pulse_d;
   logic             new_high_q, new_high_d;
   logic [1:0]       passed_q, passed_d;

   logic             rise, fall;
   logic [END_W-1:0] end1, end2, bird_ext;
   logic [1:0]       pass, back;
   logic [INC_W-1:0] inc;
   logic [BCD_W-1:0] sum;

   assign rise = game_state & ~gs_q;
   assign fall = ~game_state & gs_q;

   // Right edge of each pillar at 11 bits so x + width never wraps.
   assign bird_ext = {1'b0, bird_x};
   assign end1     = {1'b0, pillar1_x} + {1'b0, PILLAR_W};
   assign end2     = {1'b0, pillar2_x} + {1'b0, PILLAR_W};
   assign back     = {end2 >= bird_ext, end1 >= bird_ext};
   assign pass     = ~back & ~passed_q;
   assign inc      = {1'b0, pass[0]} + {1'b0, pass[1]};

   bcd_add_sat #(
      .SAT_VALUE(SCORE_MAX)
   ) u_add (
      .bcd_i(score_q),
      .inc_i(inc),
      .sum_o(sum)
   );

   always_comb begin
      state_d    = state_q;
      score_d    = score_q;
      high_d     = high_q;
      passed_d   = passed_q;
      pulse_d    = 1'b0;
      new_high_d = 1'b0;
      case (state_q)
         ST_IDLE, ST_OVER: begin
            if (rise) begin
               state_d  = ST_PLAYING;
               score_d  = '0;
               passed_d = '0;
            end
         end
         ST_PLAYING: begin
            // A falling game_state takes priority over a coincident tick.
            if (fall) begin
               state_d = ST_COMMIT;
            end else if (game_tick) begin
               score_d  = sum;
               pulse_d  = (inc != '0);
               passed_d = pass | (passed_q & ~back);
            end
         end
         ST_COMMIT: begin
            if (score_q > high_q) begin
               high_d     = score_q;
               new_high_d = 1'b1;
            end
            state_d = ST_OVER;
         end
         default: state_d = ST_IDLE;
      endcase
      disp_d = ((state_d == ST_PLAYING) || (state_d == ST_COMMIT)) ? score_d : high_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         gs_q       <= 1'b0;
         score_q    <= '0;
         high_q     <= '0;
         disp_q     <= '0;
         pulse_q    <= 1'b0;
         new_high_q <= 1'b0;
         passed_q   <= '0;
      end else begin
         state_q    <= state_d;
         gs_q       <= game_state;
         score_q    <= score_d;
         high_q     <= high_d;
         disp_q     <= disp_d;
         pulse_q    <= pulse_d;
         new_high_q <= new_high_d;
         passed_q   <= passed_d;
      end
   end

   assign score_bcd   = score_q;
   assign high_bcd    = high_q;
   assign disp_bcd    = disp_q;
   assign score_pulse = pulse_q;
   assign new_high    = new_high_q;

endmodule : score_keeper

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper: decimal reference model, BCD-converted expectations.
module tb_score_keeper;

   logic        clk;
   logic        rst_n;
   logic        game_tick;
   logic        game_state;
   logic [9:0]  bird_x;
   logic [9:0]  pillar1_x;
   logic [9:0]  pillar2_x;
   logic [15:0] score_bcd;
   logic [15:0] high_bcd;
   logic [15:0] disp_bcd;
   logic        score_pulse;
   logic        new_high;

   typedef struct packed {
      logic [15:0] score;
      logic        pulse;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   int   m_score = 0;
   int   m_high = 0;
   bit   m_playing = 0;
   bit   m_passed1 = 0;
   bit   m_passed2 = 0;

   score_keeper dut (
      .clk(clk), .rst_n(rst_n), .game_tick(game_tick), .game_state(game_state),
      .bird_x(bird_x), .pillar1_x(pillar1_x), .pillar2_x(pillar2_x),
      .score_bcd(score_bcd), .high_bcd(high_bcd), .disp_bcd(disp_bcd),
      .score_pulse(score_pulse), .new_high(new_high)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] to_bcd(input int v);
      return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
   endfunction

   function automatic int model_pillar(input logic [9:0] px, inout bit passed);
      int e;
      e = int'(px) + 40;
      if (e < int'(bird_x)) begin
         if (!passed) begin
            passed = 1'b1;
            return 1;
         end
      end else begin
         passed = 1'b0;
      end
      return 0;
   endfunction

   // One game tick: model predicts, pushes, DUT edge, pop and compare.
   task automatic do_tick(input logic [9:0] p1, input logic [9:0] p2, input bit chk);
      exp_t e;
      int   inc;
      pillar1_x = p1;
      pillar2_x = p2;
      game_tick = 1'b1;
      inc = 0;
      if (m_playing) begin
         inc += model_pillar(p1, m_passed1);
         inc += model_pillar(p2, m_passed2);
         m_score = (m_score + inc > 9999) ? 9999 : m_score + inc;
      end
      e.score = to_bcd(m_score);
      e.pulse = (inc != 0);
      sb.push_back(e);
      @(posedge clk);
      #1;
      game_tick = 1'b0;
      e = sb.pop_front();
      if (chk) begin
         checks += 3;
         if (score_bcd !== e.score) begin
            errors++;
            $display("FAIL tick_score got %h exp %h", score_bcd, e.score);
         end
         if (score_pulse !== e.pulse) begin
            errors++;
            $display("FAIL tick_pulse got %b exp %b", score_pulse, e.pulse);
         end
         if (disp_bcd !== (m_playing ? e.score : to_bcd(m_high))) begin
            errors++;
            $display("FAIL tick_disp got %h exp %h", disp_bcd,
                     m_playing ? e.score : to_bcd(m_high));
         end
      end
   endtask

   task automatic single_pass();
      do_tick(10'd600, 10'd600, 1'b1);
      do_tick(10'd59, 10'd600, 1'b1);
   endtask

   task automatic start_game();
      game_state = 1'b1;
      @(posedge clk);
      #1;
      m_playing = 1'b1;
      m_score   = 0;
      m_passed1 = 1'b0;
      m_passed2 = 1'b0;
      checks += 2;
      if (score_bcd !== 16'h0000) begin
         errors++;
         $display("FAIL start_score got %h exp 0000", score_bcd);
      end
      if (disp_bcd !== 16'h0000) begin
         errors++;
         $display("FAIL start_disp got %h exp 0000", disp_bcd);
      end
   endtask

   // Fall with a coincident scoring tick; the tick must be ignored.
   task automatic end_game();
      bit exp_nh;
      game_state = 1'b0;
      game_tick  = 1'b1;
      pillar1_x  = 10'd59;
      pillar2_x  = 10'd59;
      @(posedge clk);
      #1;
      game_tick = 1'b0;
      m_playing = 1'b0;
      checks += 3;
      if (score_bcd !== to_bcd(m_score) || score_pulse !== 1'b0) begin
         errors++;
         $display("FAIL fall_tick score %h pulse %b exp %h 0", score_bcd, score_pulse,
                  to_bcd(m_score));
      end
      if (disp_bcd !== to_bcd(m_score)) begin
         errors++;
         $display("FAIL commit_disp got %h exp %h", disp_bcd, to_bcd(m_score));
      end
      if (new_high !== 1'b0) begin
         errors++;
         $display("FAIL commit_nh_early got %b exp 0", new_high);
      end
      exp_nh = (m_score > m_high);
      if (exp_nh) m_high = m_score;
      @(posedge clk);
      #1;
      checks += 3;
      if (high_bcd !== to_bcd(m_high)) begin
         errors++;
         $display("FAIL commit_high got %h exp %h", high_bcd, to_bcd(m_high));
      end
      if (new_high !== exp_nh) begin
         errors++;
         $display("FAIL commit_new_high got %b exp %b", new_high, exp_nh);
      end
      if (disp_bcd !== to_bcd(m_high)) begin
         errors++;
         $display("FAIL over_disp got %h exp %h", disp_bcd, to_bcd(m_high));
      end
      @(posedge clk);
      #1;
      checks++;
      if (new_high !== 1'b0) begin
         errors++;
         $display("FAIL new_high_width got %b exp 0", new_high);
      end
   endtask

   task automatic check_all_zero(input string name);
      checks++;
      if ({score_bcd, high_bcd, disp_bcd, score_pulse, new_high} !== 50'd0) begin
         errors++;
         $display("FAIL %s score %h high %h disp %h pulse %b nh %b exp all 0", name,
                  score_bcd, high_bcd, disp_bcd, score_pulse, new_high);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      game_state = 1'b0;
      game_tick = 1'b0;
      bird_x = 10'd100;
      pillar1_x = 10'd600;
      pillar2_x = 10'd600;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_first_pass();
      start_game();
      do_tick(10'd70, 10'd600, 1'b1);
      do_tick(10'd59, 10'd600, 1'b1);
      do_tick(10'd50, 10'd600, 1'b1);
      do_tick(10'd30, 10'd600, 1'b1);
   endtask

   task automatic test_double_and_carry();
      repeat (8) single_pass();
      do_tick(10'd600, 10'd600, 1'b1);
      do_tick(10'd70, 10'd70, 1'b1);
      do_tick(10'd59, 10'd59, 1'b1);
      single_pass();
      checks++;
      if (score_bcd !== 16'h0012) begin
         errors++;
         $display("FAIL carry_12 got %h exp 0012", score_bcd);
      end
      do_tick(10'd600, 10'd600, 1'b1);
      end_game();
   endtask

   task automatic test_replay();
      start_game();
      repeat (5) single_pass();
      do_tick(10'd600, 10'd600, 1'b1);
      end_game();
   endtask

   task automatic test_reset_mid();
      start_game();
      repeat (7) single_pass();
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      game_state = 1'b0;
      #1;
      check_all_zero("async_reset");
      m_playing = 1'b0;
      m_score = 0;
      m_high = 0;
      m_passed1 = 1'b0;
      m_passed2 = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      do_tick(10'd600, 10'd600, 1'b1);
      do_tick(10'd59, 10'd59, 1'b1);
      check_all_zero("idle_tick");
   endtask

   task automatic test_saturation();
      start_game();
      for (int i = 0; i < 4999; i++) begin
         do_tick(10'd59, 10'd59, 1'b0);
         do_tick(10'd600, 10'd600, 1'b0);
      end
      checks++;
      if (score_bcd !== 16'h9998) begin
         errors++;
         $display("FAIL bulk_9998 got %h exp 9998", score_bcd);
      end
      do_tick(10'd59, 10'd59, 1'b1);
      do_tick(10'd600, 10'd600, 1'b1);
      do_tick(10'd59, 10'd59, 1'b1);
      do_tick(10'd600, 10'd600, 1'b1);
      end_game();
   endtask

   initial begin
      test_reset();
      test_first_pass();
      test_double_and_carry();
      test_replay();
      test_reset_mid();
      test_saturation();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_leftover got %0d exp 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_score_keeper
